// File: rtl/xz_merge_pkg.sv
// Shared types and helpers for the X/Z constant merge pipeline.
// Marker resolution is done at a fixed maximum width and sliced by users.
package xz_merge_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_ONE  = 2'd1,
    MODE_XZ   = 2'd2,
    MODE_SUB  = 2'd3
  } mode_e;

  localparam int MARK_MAX = 64;
  typedef logic [MARK_MAX-1:0] mark_t;

  localparam logic [31:0] DEF_CONST_VAL = 32'h0BD0_0000;
  localparam logic [31:0] DEF_CONST_UNK = 32'h000F_FFF0;
  localparam logic [31:0] DEF_CONST_ISZ = 32'h0005_AF00;

  function automatic mark_t resolve_marker(
    input mode_e mode,
    input mark_t sub_bits,
    input mark_t val,
    input mark_t unk,
    input mark_t isz
  );
    mark_t fill;
    unique case (mode)
      MODE_ZERO: fill = '0;
      MODE_ONE:  fill = '1;
      MODE_XZ:   fill = isz;
      MODE_SUB:  fill = sub_bits;
    endcase
    return (val & ~unk) | (fill & unk);
  endfunction

endpackage

// File: rtl/xz_pipe_stage.sv
// One elastic pipeline slot: a valid bit plus payload register.
// Loads whenever empty or draining in the same cycle.
module xz_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/xz_const_merge_pipe.sv
// Elastic pipeline merging a resolved X/Z marker constant with the
// low slice of the input word; reports the unknown/Z positions.
module xz_const_merge_pipe
  import xz_merge_pkg::*;
#(
  parameter int DATA_W  = 121,
  parameter int SLICE_W = 32,
  parameter int CONST_W = 32,
  parameter logic [CONST_W-1:0] CONST_VAL = CONST_W'(DEF_CONST_VAL),
  parameter logic [CONST_W-1:0] CONST_UNK = CONST_W'(DEF_CONST_UNK),
  parameter logic [CONST_W-1:0] CONST_ISZ = CONST_W'(DEF_CONST_ISZ),
  parameter int STAGES  = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [CONST_W+SLICE_W-1:0] out_word,
  output logic [CONST_W-1:0]         out_unk_mask,
  output logic [CONST_W-1:0]         out_z_mask,
  output logic [CNT_W-1:0]           xfer_cnt
);

  localparam int PW = CONST_W + DATA_W;

  logic [CONST_W-1:0] sub_bits;
  logic [CONST_W-1:0] marker;
  logic [PW-1:0]      last_d;

  // Bits past the top of in_data have nothing to borrow from.
  for (genvar i = 0; i < CONST_W; i++) begin : g_sub
    if (SLICE_W + i < DATA_W) begin : g_in
      assign sub_bits[i] = in_data[SLICE_W+i];
    end else begin : g_zero
      assign sub_bits[i] = 1'b0;
    end
  end

  assign marker = CONST_W'(resolve_marker(
    mode_e'(in_mode),
    mark_t'(sub_bits),
    mark_t'(CONST_VAL),
    mark_t'(CONST_UNK),
    mark_t'(CONST_ISZ)));

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          up_v;
    logic          up_r;
    logic [PW-1:0] up_d;
    logic          dn_v;
    logic          dn_r;
    logic [PW-1:0] dn_d;

    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = {marker, in_data};
    end else begin : g_link
      assign up_v = g_stage[k-1].dn_v;
      assign up_d = g_stage[k-1].dn_d;
    end

    if (k == STAGES - 1) begin : g_tail
      assign dn_r = out_ready;
    end else begin : g_back
      assign dn_r = g_stage[k+1].up_r;
    end

    xz_pipe_stage #(.W(PW)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_v),
      .up_ready (up_r),
      .up_data  (up_d),
      .dn_valid (dn_v),
      .dn_ready (dn_r),
      .dn_data  (dn_d)
    );
  end

  assign in_ready  = g_stage[0].up_r;
  assign out_valid = g_stage[STAGES-1].dn_v;
  assign last_d    = g_stage[STAGES-1].dn_d;

  assign out_data     = last_d[DATA_W-1:0];
  assign out_word     = {last_d[PW-1:DATA_W], last_d[SLICE_W-1:0]};
  assign out_unk_mask = out_valid ? CONST_UNK : '0;
  assign out_z_mask   = out_valid ? CONST_ISZ : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready && xfer_cnt != '1) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_xz_const_merge_pipe.sv
// Directed bench for xz_const_merge_pipe with hand-computed vectors.
// A second instance with a 4-bit counter exercises saturation.
module tb_xz_const_merge_pipe;

  localparam int DW = 121;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_mode;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [63:0]   out_word;
  logic [31:0]   out_unk_mask, out_z_mask;
  logic [15:0]   xfer_cnt;

  logic          s_in_valid, s_in_ready;
  logic [DW-1:0] s_in_data;
  logic [1:0]    s_in_mode;
  logic          s_out_valid, s_out_ready;
  logic [DW-1:0] s_out_data;
  logic [63:0]   s_out_word;
  logic [31:0]   s_unk, s_z;
  logic [3:0]    s_xfer_cnt;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  xz_const_merge_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_word     (out_word),
    .out_unk_mask (out_unk_mask),
    .out_z_mask   (out_z_mask),
    .xfer_cnt     (xfer_cnt)
  );

  xz_const_merge_pipe #(.CNT_W(4)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (s_in_valid),
    .in_ready     (s_in_ready),
    .in_data      (s_in_data),
    .in_mode      (s_in_mode),
    .out_valid    (s_out_valid),
    .out_ready    (s_out_ready),
    .out_data     (s_out_data),
    .out_word     (s_out_word),
    .out_unk_mask (s_unk),
    .out_z_mask   (s_z),
    .xfer_cnt     (s_xfer_cnt)
  );

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] k;
    k = 32'(i);
    return {k[24:0], 32'hFACE_0000 + k,
            32'h0101_0101 * k, 32'hC0DE_0000 | k};
  endfunction

  // Streams n mode-0 words; out_ready is low for cycles st_lo..st_hi.
  task automatic run_stream(
    input  int n,
    input  int st_lo,
    input  int st_hi,
    output int cycles,
    output int gaps,
    output bit saw_full
  );
    int nsent = 0;
    int nrecv = 0;
    int c = 0;
    bit have_hold = 1'b0;
    logic [DW-1:0] hold_d;
    logic [63:0]   hold_w;
    logic [DW-1:0] e;
    gaps = 0;
    saw_full = 1'b0;
    while (nrecv < n && c < 3 * n + 20) begin
      in_valid  = (nsent < n);
      in_data   = pat(nsent);
      in_mode   = 2'd0;
      out_ready = !(c >= st_lo && c <= st_hi);
      @(negedge clk);
      if (!out_ready) begin
        if (!in_ready) saw_full = 1'b1;
        if (out_valid && have_hold) begin
          check("stall_data", out_data, hold_d);
          check("stall_word", out_word, hold_w);
        end else if (out_valid) begin
          have_hold = 1'b1;
          hold_d = out_data;
          hold_w = out_word;
        end
      end else begin
        have_hold = 1'b0;
      end
      if (out_valid && out_ready) begin
        e = pat(nrecv);
        check("stream_data", out_data, e);
        check("stream_word", out_word, {32'h0BD0_0000, e[31:0]});
        nrecv++;
      end else if (c >= 2) begin
        gaps++;
      end
      if (in_valid && in_ready) nsent++;
      tick();
      c++;
    end
    in_valid = 1'b0;
    check("stream_count", nrecv, n);
    cycles = c;
  endtask

  logic [DW-1:0] d0;
  logic [63:0]   mexp [3];
  int  cyc, gp, stale;
  bit  full;

  initial begin
    d0 = {57'd0, 64'h12345678_DEADBEEF};
    mexp[0] = 64'h0BDF_FFF0_DEAD_BEEF;
    mexp[1] = 64'h0BD5_AF00_DEAD_BEEF;
    mexp[2] = 64'h0BD4_5670_DEAD_BEEF;

    rst_n = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_mode = 2'd0;
    out_ready = 1'b1;
    s_in_valid = 1'b0;
    s_in_data = d0;
    s_in_mode = 2'd0;
    s_out_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_cnt", xfer_cnt, 0);
    check("rst_data", out_data, 0);
    check("rst_word", out_word, 0);
    check("rst_unk", out_unk_mask, 0);
    check("rst_z", out_z_mask, 0);
    #3 rst_n = 1'b1;
    tick();
    check("rst_ready", in_ready, 1);

    // single word, mode 0
    in_valid = 1'b1;
    in_data = d0;
    in_mode = 2'd0;
    tick();
    in_valid = 1'b0;
    check("lat_early", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("m0_word", out_word, 64'h0BD0_0000_DEAD_BEEF);
    check("m0_data", out_data, d0);
    check("m0_unk", out_unk_mask, 32'h000F_FFF0);
    check("m0_z", out_z_mask, 32'h0005_AF00);
    tick();
    check("m0_cnt", xfer_cnt, 1);
    check("m0_drain", out_valid, 0);

    // modes 1..3 back to back
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3);
      in_data = d0;
      in_mode = 2'(i + 1);
      tick();
      if (i >= 1 && i <= 3) begin
        check("mode_valid", out_valid, 1);
        check("mode_word", out_word, mexp[i-1]);
      end
    end
    check("mode_cnt", xfer_cnt, 4);

    // backpressure
    pulse_reset();
    tick();
    run_stream(6, 3, 7, cyc, gp, full);
    check("bp_full", full, 1);
    check("bp_cnt", xfer_cnt, 6);

    // full throughput
    pulse_reset();
    tick();
    run_stream(100, -1, -1, cyc, gp, full);
    check("tp_cycles", cyc, 102);
    check("tp_gaps", gp, 0);
    check("tp_cnt", xfer_cnt, 100);

    // saturation on the 4-bit counter
    s_in_valid = 1'b1;
    repeat (10) tick();
    check("sat_mid", s_xfer_cnt, 8);
    repeat (10) tick();
    s_in_valid = 1'b0;
    repeat (4) tick();
    check("sat_hold", s_xfer_cnt, 15);

    // reset with two words in flight
    in_valid = 1'b1;
    in_data = pat(0);
    tick();
    in_data = pat(1);
    tick();
    in_valid = 1'b0;
    check("mr_inflight", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_cnt", xfer_cnt, 0);
    check("mr_data", out_data, 0);
    #2 rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      tick();
      if (out_valid) stale++;
    end
    check("mr_stale", stale, 0);
    check("mr_cnt_after", xfer_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
